// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - servo position slew controller feeding a downstream PWM generator
// Define SERVO_RAMP_EN to limit motion to RAMP_STEP degrees per frame; otherwise position jumps per frame.
module servo_ramp_ctrl #(
  parameter int unsigned PERIOD    = 1000000,
  parameter int unsigned MIN_ON    = 50000,
  parameter int unsigned STEP      = 278,
  parameter int unsigned RAMP_STEP = 2,
  parameter int unsigned MAX_POS   = 180,
  parameter int unsigned CENTER    = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_pos,
  output logic        cmd_ready,
  input  logic        pwm_in,
  output logic [31:0] rise,
  output logic [31:0] fall,
  output logic        busy,
  output logic [7:0]  cur_pos
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [31:0] PERIOD32 = 32'(PERIOD);
  localparam logic [31:0] MIN_ON32 = 32'(MIN_ON);
  localparam logic [31:0] STEP32   = 32'(STEP);
  localparam logic [7:0]  MAX8     = 8'(MAX_POS);
  localparam logic [7:0]  CENTER8  = 8'(CENTER);
  localparam logic [31:0] RISE_RST = MIN_ON32 + 32'(CENTER) * STEP32;

  state_t      state;
  logic        pwm_d;
  logic        tick_d;
  logic        frame_tick;
  logic        cmd_fire;
  logic [7:0]  tgt_pos;
  logic [7:0]  cmd_clamped;
  logic [7:0]  next_cur;
  logic [7:0]  next_tgt;
  logic [31:0] rise_calc;
  state_t      next_state;

  assign frame_tick = pwm_in & ~pwm_d;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign rise_calc  = MIN_ON32 + {24'd0, cur_pos} * STEP32;

`ifdef SERVO_RAMP_EN
  logic [7:0] diff;
  logic [7:0] step;
  localparam logic [7:0] RAMP8 = 8'(RAMP_STEP);
`endif

  always_comb begin
    cmd_clamped = (cmd_pos > MAX8) ? MAX8 : cmd_pos;
    next_cur    = cur_pos;
`ifdef SERVO_RAMP_EN
    diff = (tgt_pos > cur_pos) ? (tgt_pos - cur_pos) : (cur_pos - tgt_pos);
    step = (diff > RAMP8) ? RAMP8 : diff;
    if (frame_tick && state == RAMP)
      next_cur = (tgt_pos > cur_pos) ? (cur_pos + step) : (cur_pos - step);
`else
    if (frame_tick && state == RAMP)
      next_cur = tgt_pos;
`endif
    // A command landing on a tick retargets only after this tick's step.
    next_tgt   = cmd_fire ? cmd_clamped : tgt_pos;
    next_state = (next_cur != next_tgt) ? RAMP : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pwm_d     <= 1'b1;
      tick_d    <= 1'b0;
      cmd_ready <= 1'b0;
      tgt_pos   <= CENTER8;
      cur_pos   <= CENTER8;
      busy      <= 1'b0;
      rise      <= RISE_RST;
      fall      <= PERIOD32 - RISE_RST;
    end else begin
      pwm_d     <= pwm_in;
      tick_d    <= frame_tick;
      cmd_ready <= 1'b1;
      tgt_pos   <= next_tgt;
      cur_pos   <= next_cur;
      state     <= next_state;
      busy      <= (next_state == RAMP);
      // Counts refresh only right after a frame boundary, never mid-frame.
      if (tick_d) begin
        rise <= rise_calc;
        fall <= PERIOD32 - rise_calc;
      end
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb/tb_servo_ramp_ctrl.sv - randomized scoreboard bench for servo_ramp_ctrl
// Follows SERVO_RAMP_EN the same way as the design build.
module tb_servo_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [7:0]  cmd_pos;
  logic        cmd_ready;
  logic        pwm_in;
  logic [31:0] rise;
  logic [31:0] fall;
  logic        busy;
  logic [7:0]  cur_pos;

  servo_ramp_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
    .cmd_ready(cmd_ready), .pwm_in(pwm_in), .rise(rise), .fall(fall),
    .busy(busy), .cur_pos(cur_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cur;
    int unsigned rs;
    int unsigned fl;
    int unsigned bsy;
  } exp_t;

  exp_t q[$];
  int   m_cur;
  int   m_tgt;
  int   errors = 0;
  int   checks = 0;
  logic pwm_prev = 1'b1;

  function automatic int unsigned exp_rise(input int c);
    return 32'd50000 + 32'(c) * 32'd278;
  endfunction

  function automatic int clamp(input int p);
    return (p > 180) ? 180 : p;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_tick();
    int d;
    d = m_tgt - m_cur;
`ifdef SERVO_RAMP_EN
    if (d > 0) m_cur += (d > 2) ? 2 : d;
    else if (d < 0) m_cur -= (-d > 2) ? 2 : -d;
`else
    m_cur = m_tgt;
`endif
  endtask

  task automatic frame(input bit with_cmd, input int pos);
    exp_t e;
    @(posedge clk); #1;
    pwm_in = 1'b1;
    if (with_cmd) begin
      cmd_valid = 1'b1;
      cmd_pos   = 8'(pos);
    end
    model_tick();
    if (with_cmd) m_tgt = clamp(pos);
    e.cur = m_cur;
    e.rs  = exp_rise(m_cur);
    e.fl  = 32'd1000000 - exp_rise(m_cur);
    e.bsy = (m_cur != m_tgt) ? 1 : 0;
    q.push_back(e);
    @(posedge clk); #1;
    pwm_in    = 1'b0;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_cmd(input int pos);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_pos   = 8'(pos);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_tgt = clamp(pos);
    @(negedge clk);
    chk("cmd_busy", busy, (m_cur != m_tgt) ? 1 : 0);
    chk("cmd_cur", cur_pos, m_cur);
  endtask

  task automatic check_reset_outputs(input int unsigned rdy);
    chk("rst_rise", rise, 75020);
    chk("rst_fall", fall, 924980);
    chk("rst_cur", cur_pos, 90);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, rdy);
  endtask

  // Monitor: a frame boundary seen on pwm_in is scored two cycles later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pwm_in && !pwm_prev && !reset) begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
          e = q.pop_front();
          chk("sb_cur", cur_pos, e.cur);
          chk("sb_rise", rise, e.rs);
          chk("sb_fall", fall, e.fl);
          chk("sb_busy", busy, e.bsy);
        end
      end
      pwm_prev = pwm_in;
    end
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_pos   = 8'd0;
    pwm_in    = 1'b0;
    m_cur     = 90;
    m_tgt     = 90;
    #1;
    check_reset_outputs(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1);

    send_cmd(100);
    repeat (6) frame(0, 0);
    send_cmd(200);
    repeat (42) frame(0, 0);
    chk("clamp_cur", cur_pos, m_cur);
    send_cmd(85);
    repeat (4) frame(0, 0);
    send_cmd(90);
    repeat (3) frame(0, 0);

    send_cmd(100);
    repeat (2) frame(0, 0);
    frame(1, 96);
    repeat (3) frame(0, 0);

    for (int i = 0; i < 25; i++) begin
      int p;
      p = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) frame(1, p);
      else send_cmd(p);
      repeat ($urandom_range(1, 6)) frame(0, 0);
    end

    send_cmd(200);
    repeat (3) frame(0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs(0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_cur = 90;
    m_tgt = 90;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1);
    repeat (2) frame(0, 0);
    send_cmd(150);
    frame(0, 0);
    repeat (32) frame(0, 0);

    repeat (10) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 Parameter PERIOD, default 1000000, PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter MIN_ON, default 50000, high-time count for 0 degrees.
REQ-003 Parameter STEP, default 278, high-time counts added per degree.
REQ-004 Parameter RAMP_STEP, default 2, maximum degrees moved per frame.
REQ-005 Parameter MAX_POS, default 180, and CENTER, default 90: position clamp limit and reset position, in degrees.
REQ-006 clk  input  1  system clock; all registers on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid  input  1  target position command present.
REQ-009 cmd_pos  input  8  commanded position in degrees, unsigned.
REQ-010 cmd_ready  output  1  command accept; a transfer occurs when cmd_valid and cmd_ready are both high on a clk edge.
REQ-011 pwm_in  input  1  PWM output fed back from the downstream generator; its rising edge marks a frame boundary.
REQ-012 rise  output  32  high-time count driven to the downstream PWM generator.
REQ-013 fall  output  32  low-time count driven to the downstream PWM generator.
REQ-014 busy  output  1  high while the current position differs from the target.
REQ-015 cur_pos  output  8  current applied position in degrees.

Function
REQ-016 An accepted cmd_pos above MAX_POS SHALL be clamped to MAX_POS and latched as tgt_pos.
REQ-017 cmd_ready SHALL be 1 in every cycle after reset deassertion; a new command overwrites tgt_pos, including mid-ramp.
REQ-018 The frame edge SHALL be detected as pwm_in=1 with a registered copy of pwm_in=0 (one-cycle pulse, frame_tick).
REQ-019 The FSM SHALL have two states: IDLE (cur_pos==tgt_pos) and RAMP (cur_pos!=tgt_pos).
REQ-020 In IDLE, a command whose clamped value differs from cur_pos SHALL move the FSM to RAMP on the next cycle.
REQ-021 In RAMP, on each frame_tick cur_pos SHALL move toward tgt_pos by min(RAMP_STEP, |tgt_pos-cur_pos|).
REQ-022 The FSM SHALL return to IDLE in the cycle after cur_pos reaches tgt_pos; cur_pos SHALL never overshoot the target.
REQ-023 On a simultaneous command and frame_tick, the step SHALL use the old tgt_pos; the new target SHALL take effect from the next frame_tick.
REQ-024 rise SHALL equal MIN_ON + cur_pos*STEP and fall SHALL equal PERIOD - rise, both registered, updating one cycle after cur_pos changes.
REQ-025 rise and fall SHALL change only in the cycle after a frame_tick or reset, so the downstream generator never sees mid-frame count changes.
REQ-026 busy SHALL be 1 exactly when the FSM is in RAMP.
REQ-027 All arithmetic SHALL be unsigned 32-bit; parameters SHALL satisfy MIN_ON + MAX_POS*STEP < PERIOD.
REQ-028 frame_tick events in IDLE SHALL leave all outputs unchanged.

Reset
REQ-029 Reset SHALL set cur_pos and tgt_pos to CENTER, the FSM to IDLE, busy to 0, cmd_ready to 0, and the pwm_in history register to 1.
REQ-030 Reset SHALL set rise to 75020 and fall to 924980 at defaults (MIN_ON + CENTER*STEP).
REQ-031 Reset asserted mid-ramp SHALL abandon the ramp immediately, with no pending step applied after release.

Configuration
REQ-032 Macro SERVO_RAMP_EN defined SHALL enable slew limiting as in REQ-021.
REQ-033 Without SERVO_RAMP_EN, cur_pos SHALL jump to tgt_pos on the first frame_tick after the command, and busy SHALL be high only until that tick.

Verification
REQ-034 Reset release -> rise=75020, fall=924980, cur_pos=90, busy=0, cmd_ready=1 on the next cycle.
REQ-035 Command 100 from 90, with frame ticks -> cur_pos 92,94,96,98,100 on five ticks; rise=75576 after the first tick; busy drops after the fifth.
REQ-036 Command 200 -> clamped; final cur_pos=180, rise=100040, fall=899960.
REQ-037 Command 85 from 90 -> cur_pos 88, 86, 85 (final partial step); no undershoot.
REQ-038 Command 96 in the same cycle as a tick during a ramp toward 100 from 94 -> that tick gives 96; the FSM goes to IDLE with no further steps.
REQ-039 Reset pulse mid-ramp at cur_pos=120 -> outputs immediately 75020/924980; build without SERVO_RAMP_EN: command 150 -> cur_pos=150 after a single tick.
